// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and barcode frame assembler.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_DONE
  } rx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef logic [12:0][3:0] scan_t;

  // Running EAN-13 checksum step: add d (or 3*d) and fold back into 0..9.
  // The sum never exceeds 9+27=36, so one of three subtractions is enough.
  function automatic logic [3:0] sum_mod10(input logic [3:0] s, input logic [3:0] d,
                                           input logic w3);
    logic [5:0] t;
    t = {2'b00, s} + (w3 ? 6'(d) * 6'd3 : 6'(d));
    if (t >= 6'd30)      t = t - 6'd30;
    else if (t >= 6'd20) t = t - 6'd20;
    else if (t >= 6'd10) t = t - 6'd10;
    return t[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, start-bit glitch filter, centre sampling.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int          CYCLE     = CLK_FRE * 1_000_000 / UART_RATE;
  localparam logic [15:0] HALF_LAST = 16'(CYCLE / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CYCLE - 1);

  logic        rx_meta_q, rx_sync_q;
  logic [1:0]  fill_q;
  logic        hi_q;
  logic        fall;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  // Synchroniser plus a "line was really high" flag. fill_q masks the reset
  // value of the synchroniser so a line held low across reset release is not
  // mistaken for a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      fill_q    <= 2'b00;
      hi_q      <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      fill_q    <= {fill_q[0], 1'b1};
      hi_q      <= fill_q[1] & rx_sync_q;
    end
  end

  assign fall = hi_q & ~rx_sync_q;

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: start bit checked at half a bit, data and stop at bit centres.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_DONE : RX_IDLE;
        end
      end
      RX_DONE: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_valid = (state_q == RX_DONE);
  assign rx_byte  = shift_q;

endmodule

// File: rtl/uart_rx_scan.sv
// Assembles ASCII digit lines from the UART into a checked EAN-13 code.
module uart_rx_scan
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200,
  parameter int DIGITS    = 13
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  uart_rx,
  output scan_t scan_data,
  output logic  scan_valid,
  output logic  scan_err
);

  localparam logic [3:0] NDIG = 4'(DIGITS);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       is_digit, is_term;

  logic [3:0] cnt_q, cnt_d;
  logic       bad_q, bad_d;
  logic [3:0] sum_q, sum_d;
  scan_t      stage_q, stage_d;
  scan_t      data_q, data_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  uart_rx_byte #(
    .CLK_FRE  (CLK_FRE),
    .UART_RATE(UART_RATE)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  assign is_digit = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
  assign is_term  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);

  // Frame assembler: one action per received byte; terminators close a line.
  always_comb begin
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    sum_d   = sum_q;
    stage_d = stage_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (rx_valid) begin
      if (is_term) begin
        // Empty clean line (or LF after CR) is silently dropped.
        if (!(cnt_q == 4'd0 && !bad_q)) begin
          if (cnt_q == NDIG && !bad_q && sum_q == 4'd0) begin
            data_d  = stage_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        cnt_d = '0;
        bad_d = 1'b0;
        sum_d = '0;
      end else if (is_digit) begin
        if (cnt_q < NDIG) begin
          stage_d = {stage_q[11:0], rx_byte[3:0]};
          cnt_d   = cnt_q + 4'd1;
          // cnt_q odd means an even 1-based position, weighted by 3.
          sum_d   = sum_mod10(sum_q, rx_byte[3:0], cnt_q[0]);
        end else begin
          bad_d = 1'b1;
        end
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  // Assembler and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      sum_q   <= '0;
      stage_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      sum_q   <= sum_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign scan_data  = data_q;
  assign scan_valid = valid_q;
  assign scan_err   = err_q;

endmodule

// File: tb/tb_uart_rx_scan.sv
// Bench for uart_rx_scan: serial stimulus, line-level reference model, event scoreboard.
module tb_uart_rx_scan;
  import uart_pkg::*;

  // Fast baud keeps the run short: 10 clocks per bit.
  localparam int CLK_FRE   = 50;
  localparam int UART_RATE = 5_000_000;
  localparam int CYC       = CLK_FRE * 1_000_000 / UART_RATE;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  uart_rx = 1'b1;
  scan_t scan_data;
  logic  scan_valid, scan_err;

  uart_rx_scan #(.CLK_FRE(CLK_FRE), .UART_RATE(UART_RATE), .DIGITS(13)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .scan_data (scan_data),
    .scan_valid(scan_valid),
    .scan_err  (scan_err)
  );

  always #10 clk = ~clk;

  typedef struct packed { logic ok; scan_t data; } ev_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  bit   both_seen = 0;

  // Reference model state: digits of the current line, sticky bad flag,
  // last accepted code.
  int    dig_q[$];
  bit    m_bad = 0;
  scan_t m_last = '0;

  // Output monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_valid && scan_err) both_seen = 1;
      if (scan_valid || scan_err) obs_q.push_back({scan_valid, scan_data});
    end
  end

  function automatic bit ean_ok();
    int s = 0;
    foreach (dig_q[i]) s += dig_q[i] * ((i % 2) ? 3 : 1);
    return (s % 10) == 0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (b == 8'h0D || b == 8'h0A) begin
      if (dig_q.size() == 0 && !m_bad) begin
      end else if (dig_q.size() == 13 && !m_bad && ean_ok()) begin
        foreach (dig_q[i]) m_last[12-i] = 4'(dig_q[i]);
        e = {1'b1, m_last};
        exp_q.push_back(e);
      end else begin
        e = {1'b0, m_last};
        exp_q.push_back(e);
      end
      dig_q.delete();
      m_bad = 0;
    end else if (b >= 8'h30 && b <= 8'h39) begin
      if (dig_q.size() < 13) dig_q.push_back(int'(b) - 48);
      else m_bad = 1;
    end else begin
      m_bad = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CYC) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CYC) @(negedge clk);
    uart_rx = 1'b1;
    if (stop_ok) model_byte(b);
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  // Random frame: 0 valid, 1 wrong check digit, 2 twelve digits,
  // 3 letter inside, 4 fourteen digits. Random terminator style.
  function automatic string gen_frame(input int kind);
    int    d[13];
    int    s = 0;
    string f = "";
    for (int i = 0; i < 12; i++) begin
      d[i] = int'($urandom_range(0, 9));
      s += d[i] * ((i % 2) ? 3 : 1);
    end
    d[12] = (10 - s % 10) % 10;
    if (kind == 1) d[12] = (d[12] + 1 + int'($urandom_range(0, 8))) % 10;
    for (int i = 0; i < 13; i++) begin
      if (kind == 2 && i == 12) break;
      if (kind == 3 && i == 5) f = $sformatf("%s%c", f, 8'(65 + $urandom_range(0, 25)));
      else f = $sformatf("%s%c", f, 8'(48 + d[i]));
    end
    if (kind == 4) f = {f, "7"};
    case ($urandom_range(0, 2))
      0:       f = {f, "\n"};
      1:       f = {f, "\r\n"};
      default: f = {f, "\r"};
    endcase
    return f;
  endfunction

  task automatic test_reset();
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (scan_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", scan_data); end
    n_cmp++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", scan_valid); end
    n_cmp++; if (scan_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", scan_err); end
    // Line held low across reset release must not start a byte.
    uart_rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * CYC) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL reset_low_line: got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_valid();
    send_str("6901234567892\r\n", 2 * CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL valid_count: got %0d want 1", obs_q.size()); end
    n_cmp++; if (scan_data[12] !== 4'd6 || scan_data[0] !== 4'd2) begin n_bad++; $display("FAIL valid_digits: got [12]=%0d [0]=%0d want 6 2", scan_data[12], scan_data[0]); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL valid_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL valid_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_check();
    send_str("6901234567891\n", CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL badchk_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL badchk_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (scan_data !== m_last) begin n_bad++; $display("FAIL badchk_hold: got %h want %h", scan_data, m_last); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_length();
    send_str("690123456789\n", CYC);
    send_str("69012345678920\n", CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL length_count: got %0d want 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL length_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_char();
    send_str("69012A4567892\n", CYC);
    send_str("\r\n", CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL badchar_count: got %0d want 1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL badchar_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    // 0.3-bit low pulse, then a byte whose stop bit is low.
    uart_rx = 1'b0;
    repeat (CYC * 3 / 10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CYC) @(negedge clk);
    send_byte(8'h35, 1'b0);
    repeat (2 * CYC) @(negedge clk);
    send_str("4006381333931\n", CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL glitch_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL glitch_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    send_str("6901234", CYC);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({scan_data, scan_valid, scan_err} !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %h/%b/%b want 0", scan_data, scan_valid, scan_err); end
    rst_n = 1'b1;
    dig_q.delete(); m_bad = 0; m_last = '0;
    repeat (2 * CYC) @(negedge clk);
    send_str("9780306406157\n", CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) send_str(gen_frame(f == 1 ? 1 : 0), 0);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) send_str(gen_frame(int'($urandom_range(0, 4))), int'($urandom_range(0, 2)) * CYC);
    repeat (3 * CYC) @(negedge clk);
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (scan_data !== m_last) begin n_bad++; $display("FAIL rand_data: got %h want %h", scan_data, m_last); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_valid();
    test_bad_check();
    test_length();
    test_bad_char();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL exclusive_pulses: got %b want 0", both_seen); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
